// File: rtl/rename_tag_allocator.sv
// Rename tag free-list with a 4-level branch checkpoint ring.
// Hands out the lowest free tag, recycles tags on writeback and squashes speculative tags on mispredict.
module rename_tag_allocator #(
   parameter int unsigned TAG_W    = 4,
   parameter int unsigned NUM_TAGS = 15,
   parameter int unsigned LEVELS   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rdy,
   input  logic             allocEn,
   output logic [TAG_W-1:0] allocTag,
   output logic             allocValid,
   input  logic             ALUwrtEn,
   input  logic [TAG_W-1:0] ALUwrtTag,
   input  logic             LSwrtEn,
   input  logic [TAG_W-1:0] LSwrtTag,
   input  logic             branchDeeper,
   input  logic             bFreeEn,
   input  logic             misTaken,
   output logic             branchFull,
   output logic [TAG_W-1:0] freeCnt
);

   localparam int unsigned PTR_W = $clog2(LEVELS);

   logic [NUM_TAGS-1:0] busy_q, busy_d;
   logic [NUM_TAGS-1:0] spec_q [LEVELS];
   logic [NUM_TAGS-1:0] spec_d [LEVELS];
   logic [PTR_W-1:0]    head_q, head_d;
   logic [PTR_W-1:0]    tail_q, tail_d;

   logic [PTR_W-1:0]    nxt_head, nxt_tail, ring_occ;
   logic [TAG_W-1:0]    alloc_tag;
   logic                alloc_valid;
   logic [TAG_W-1:0]    free_cnt;
   logic                branch_full, ring_empty;
   logic                alloc_fire, push, pop, flush;
   logic [NUM_TAGS-1:0] wb_clr;
   logic [LEVELS-1:0]   flush_lvl;

   assign nxt_head    = head_q + 1'b1;
   assign nxt_tail    = tail_q + 1'b1;
   assign ring_occ    = tail_q - head_q;
   assign ring_empty  = (head_q == tail_q);
   assign branch_full = (nxt_tail == head_q);

   // Lowest free index wins; all-ones is the tagFree encoding when nothing is free.
   always_comb begin
      alloc_tag   = '1;
      alloc_valid = 1'b0;
      for (int i = int'(NUM_TAGS) - 1; i >= 0; i--) begin
         if (!busy_q[i]) begin
            alloc_tag   = TAG_W'(i);
            alloc_valid = 1'b1;
         end
      end
   end

   always_comb begin
      free_cnt = '0;
      for (int i = 0; i < int'(NUM_TAGS); i++) begin
         free_cnt = free_cnt + {{(TAG_W-1){1'b0}}, ~busy_q[i]};
      end
   end

   assign allocTag   = alloc_tag;
   assign allocValid = alloc_valid;
   assign branchFull = branch_full;
   assign freeCnt    = free_cnt;

   // misTaken flushes the front end, so it also kills allocation and branch pushes.
   assign alloc_fire = allocEn & alloc_valid & ~misTaken;
   assign push       = branchDeeper & ~branch_full & ~misTaken;
   assign pop        = bFreeEn & ~misTaken & ~ring_empty;
   assign flush      = bFreeEn & misTaken & ~ring_empty;

   always_comb begin
      wb_clr = '0;
      if (ALUwrtEn && (int'(ALUwrtTag) < int'(NUM_TAGS))) begin
         wb_clr[ALUwrtTag] = 1'b1;
      end
      if (LSwrtEn && (int'(LSwrtTag) < int'(NUM_TAGS))) begin
         wb_clr[LSwrtTag] = 1'b1;
      end
   end

   // Levels strictly younger than head, up to and including tail, in ring order.
   always_comb begin
      flush_lvl = '0;
      for (int l = 0; l < int'(LEVELS); l++) begin
         logic [PTR_W-1:0] off;
         off = PTR_W'(l) - head_q;
         flush_lvl[l] = (off != '0) && (off <= ring_occ);
      end
   end

   always_comb begin
      busy_d = busy_q;
      spec_d = spec_q;
      head_d = head_q;
      tail_d = tail_q;

      if (flush) begin
         for (int l = 0; l < int'(LEVELS); l++) begin
            if (flush_lvl[l]) begin
               busy_d    = busy_d & ~spec_q[l];
               spec_d[l] = '0;
            end
         end
         tail_d = head_q;
      end else begin
         // Allocation is charged to the current tail before any push moves it.
         if (alloc_fire) begin
            busy_d[alloc_tag]         = 1'b1;
            spec_d[tail_q][alloc_tag] = 1'b1;
         end
         if (push) begin
            tail_d           = nxt_tail;
            spec_d[nxt_tail] = '0;
         end
         if (pop) begin
            head_d         = nxt_head;
            spec_d[head_q] = '0;
         end
      end

      busy_d = busy_d & ~wb_clr;
      for (int l = 0; l < int'(LEVELS); l++) begin
         spec_d[l] = spec_d[l] & ~wb_clr;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy_q <= '0;
         head_q <= '0;
         tail_q <= '0;
         for (int l = 0; l < int'(LEVELS); l++) begin
            spec_q[l] <= '0;
         end
      end else if (rdy) begin
         busy_q <= busy_d;
         head_q <= head_d;
         tail_q <= tail_d;
         for (int l = 0; l < int'(LEVELS); l++) begin
            spec_q[l] <= spec_d[l];
         end
      end
   end

endmodule

// File: tb/tb_rename_tag_allocator.sv
// Self-checking bench for rename_tag_allocator: directed test-plan scenarios plus randomized traffic
// compared against a queue-of-levels reference model.
module tb_rename_tag_allocator;

   localparam int NT = 15;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       rdy, allocEn, ALUwrtEn, LSwrtEn, branchDeeper, bFreeEn, misTaken;
   logic [3:0] ALUwrtTag, LSwrtTag;
   logic [3:0] allocTag, freeCnt;
   logic       allocValid, branchFull;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference: busy bits plus a queue of levels, index 0 = oldest (head), last = current tail.
   bit [NT-1:0] m_busy;
   bit [NT-1:0] m_lvl[$];

   rename_tag_allocator dut (
      .clk(clk), .rst(rst), .rdy(rdy), .allocEn(allocEn), .allocTag(allocTag),
      .allocValid(allocValid), .ALUwrtEn(ALUwrtEn), .ALUwrtTag(ALUwrtTag), .LSwrtEn(LSwrtEn),
      .LSwrtTag(LSwrtTag), .branchDeeper(branchDeeper), .bFreeEn(bFreeEn), .misTaken(misTaken),
      .branchFull(branchFull), .freeCnt(freeCnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int model_tag();
      for (int i = 0; i < NT; i++) if (!m_busy[i]) return i;
      return 15;
   endfunction

   function automatic int model_cnt();
      int c = 0;
      for (int i = 0; i < NT; i++) if (!m_busy[i]) c++;
      return c;
   endfunction

   task automatic model_reset();
      m_busy = '0;
      m_lvl.delete();
      m_lvl.push_back('0);
   endtask

   task automatic model_update();
      bit [NT-1:0] clr, tmp;
      int t;
      bit full, one;
      if (!rdy) return;
      t    = model_tag();
      full = (m_lvl.size() == 4);
      one  = (m_lvl.size() == 1);
      clr  = '0;
      if (ALUwrtEn && ALUwrtTag < 15) clr[ALUwrtTag] = 1'b1;
      if (LSwrtEn && LSwrtTag < 15) clr[LSwrtTag] = 1'b1;
      if (bFreeEn && misTaken && !one) begin
         for (int i = 1; i < m_lvl.size(); i++) m_busy &= ~m_lvl[i];
         while (m_lvl.size() > 1) void'(m_lvl.pop_back());
      end else if (!misTaken) begin
         if (allocEn && t < 15) begin
            m_busy[t] = 1'b1;
            tmp = m_lvl[m_lvl.size()-1];
            tmp[t] = 1'b1;
            m_lvl[m_lvl.size()-1] = tmp;
         end
         if (branchDeeper && !full) m_lvl.push_back('0);
         if (bFreeEn && !one) void'(m_lvl.pop_front());
      end
      m_busy &= ~clr;
      for (int i = 0; i < m_lvl.size(); i++) m_lvl[i] &= ~clr;
   endtask

   task automatic check_outputs();
      check("allocTag", 32'(allocTag), 32'(model_tag()));
      check("allocValid", 32'(allocValid), 32'(model_cnt() != 0));
      check("freeCnt", 32'(freeCnt), 32'(model_cnt()));
      check("branchFull", 32'(branchFull), 32'(m_lvl.size() == 4));
   endtask

   task automatic idle();
      rdy = 1'b1; allocEn = 1'b0; ALUwrtEn = 1'b0; LSwrtEn = 1'b0;
      ALUwrtTag = 4'hF; LSwrtTag = 4'hF;
      branchDeeper = 1'b0; bFreeEn = 1'b0; misTaken = 1'b0;
   endtask

   // Check current outputs against the model, clock once, advance the model, then idle inputs.
   task automatic step();
      check_outputs();
      @(posedge clk);
      model_update();
      #1;
      idle();
   endtask

   // Asynchronous reset pulse entirely between clock edges; outputs must react before the next edge.
   task automatic async_reset(input bit explicit);
      #1 rst = 1'b0;
      #1;
      if (explicit) begin
         check("rst_allocTag", 32'(allocTag), 32'd0);
         check("rst_allocValid", 32'(allocValid), 32'd1);
         check("rst_branchFull", 32'(branchFull), 32'd0);
         check("rst_freeCnt", 32'(freeCnt), 32'd15);
      end
      model_reset();
      #1 rst = 1'b1;
   endtask

   task automatic alloc_n(input int n);
      for (int i = 0; i < n; i++) begin allocEn = 1'b1; step(); end
   endtask

   task automatic branch_seq();
      alloc_n(2);
      branchDeeper = 1'b1; step();
      alloc_n(2);
      branchDeeper = 1'b1; step();
      alloc_n(1);
   endtask

   function automatic logic [3:0] pick_wb();
      int q[$];
      for (int i = 0; i < NT; i++) if (m_busy[i]) q.push_back(i);
      if (q.size() == 0 || $urandom_range(0, 7) == 0) return 4'hF;
      return 4'(q[$urandom_range(0, q.size() - 1)]);
   endfunction

   initial begin
      idle();
      model_reset();
      #12;
      check("rst_allocTag", 32'(allocTag), 32'd0);
      check("rst_allocValid", 32'(allocValid), 32'd1);
      check("rst_branchFull", 32'(branchFull), 32'd0);
      check("rst_freeCnt", 32'(freeCnt), 32'd15);
      rst = 1'b1;
      @(posedge clk); #1;

      // Successive allocations hand out 0,1,2.
      for (int i = 0; i < 3; i++) begin
         check("seq_allocTag", 32'(allocTag), 32'(i));
         allocEn = 1'b1; step();
      end
      check("seq_freeCnt", 32'(freeCnt), 32'd12);
      check("seq_allocValid", 32'(allocValid), 32'd1);

      // Exhaust, then dual writeback.
      alloc_n(12);
      check("full_allocTag", 32'(allocTag), 32'hF);
      check("full_allocValid", 32'(allocValid), 32'd0);
      check("full_freeCnt", 32'(freeCnt), 32'd0);
      allocEn = 1'b1; step();
      ALUwrtEn = 1'b1; ALUwrtTag = 4'd7; LSwrtEn = 1'b1; LSwrtTag = 4'd3;
      check("wb_same_cycle", 32'(allocTag), 32'hF);
      step();
      check("wb_freeCnt", 32'(freeCnt), 32'd2);
      check("wb_allocTag", 32'(allocTag), 32'd3);
      allocEn = 1'b1; step();
      check("wb_allocTag2", 32'(allocTag), 32'd7);

      // Mispredict on the oldest branch squashes both younger levels.
      async_reset(1'b0);
      branch_seq();
      bFreeEn = 1'b1; misTaken = 1'b1; allocEn = 1'b1; branchDeeper = 1'b1; step();
      check("mis_freeCnt", 32'(freeCnt), 32'd13);
      check("mis_allocTag", 32'(allocTag), 32'd2);
      check("mis_branchFull", 32'(branchFull), 32'd0);

      // Resolve first branch, mispredict second: only tag 4 returns.
      async_reset(1'b0);
      branch_seq();
      bFreeEn = 1'b1; step();
      bFreeEn = 1'b1; misTaken = 1'b1; step();
      check("mis2_freeCnt", 32'(freeCnt), 32'd11);
      check("mis2_allocTag", 32'(allocTag), 32'd4);
      ALUwrtEn = 1'b1; ALUwrtTag = 4'd2; LSwrtEn = 1'b1; LSwrtTag = 4'd3; step();
      check("mis2_wb_freeCnt", 32'(freeCnt), 32'd13);
      check("mis2_wb_allocTag", 32'(allocTag), 32'd2);

      // Ring full and overflow push.
      async_reset(1'b0);
      for (int i = 0; i < 3; i++) begin branchDeeper = 1'b1; step(); end
      check("ring_full", 32'(branchFull), 32'd1);
      branchDeeper = 1'b1; step();
      check("ring_full_hold", 32'(branchFull), 32'd1);
      bFreeEn = 1'b1; step();
      check("ring_pop", 32'(branchFull), 32'd0);
      branchDeeper = 1'b1; step();
      check("ring_refill", 32'(branchFull), 32'd1);

      // rdy low freezes everything.
      async_reset(1'b0);
      alloc_n(4);
      rdy = 1'b0; allocEn = 1'b1; ALUwrtEn = 1'b1; ALUwrtTag = 4'd1; branchDeeper = 1'b1;
      step();
      check("rdy_freeCnt", 32'(freeCnt), 32'd11);
      check("rdy_allocTag", 32'(allocTag), 32'd4);
      step();

      // Async reset with tags busy.
      async_reset(1'b1);
      step();

      // Randomized traffic.
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 199) == 0) async_reset(1'b1);
         rdy          = ($urandom_range(0, 9) != 0);
         allocEn      = ($urandom_range(0, 9) < 6);
         ALUwrtEn     = ($urandom_range(0, 9) < 3);
         ALUwrtTag    = pick_wb();
         LSwrtEn      = ($urandom_range(0, 9) < 3);
         LSwrtTag     = pick_wb();
         branchDeeper = ($urandom_range(0, 9) < 2);
         bFreeEn      = ($urandom_range(0, 9) < 2);
         misTaken     = bFreeEn && ($urandom_range(0, 9) < 4);
         step();
      end
      check_outputs();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
